uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampling UART receiver with configurable data bits, parity and stop bits
// Line is sampled at mid-bit; outputs update together with a one-clk data_valid pulse.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   armed_q, armed_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   ferr_q, ferr_d;
    logic                   frame_done;
    logic                   ferr_final;

    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   break_q, break_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            ferr_q       <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            ferr_q       <= ferr_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        ferr_final = ferr_q;
        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q && !rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else if (rx_s_q) begin
                        armed_d = 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            idx_d   = '0;
                            par_d   = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            armed_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (idx_q == 4'(i)) shift_d[i] = rx_s_q;
                        end
                        if (idx_q == DATA_LAST) begin
                            idx_d   = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        par_d   = rx_s_q;
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        ferr_final = ferr_q | ~rx_s_q;
                        ferr_d     = ferr_final;
                        if (idx_q == STOP_LAST) begin
                            idx_d      = '0;
                            state_d    = S_IDLE;
                            armed_d    = ~ferr_final;
                            frame_done = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Results are captured on the edge that takes the last stop sample.
    always_comb begin
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = break_q;
        valid_d      = 1'b0;
        if (frame_done) begin
            valid_d      = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = (PARITY != 0) && ((^shift_q ^ par_q) != PAR_ODD);
            frame_err_d  = ferr_final;
            break_d      = (shift_q == '0) && !par_q && ferr_final;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg in three configurations
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic [6:0] dout_c;
    logic       dv_a, pe_a, fe_a, bk_a;
    logic       dv_b, pe_b, fe_b, bk_b;
    logic       dv_c, pe_c, fe_c, bk_c;

    int n_checks = 0;
    int n_fail = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int wide = 0;
    logic dv_a_p = 1'b0, dv_b_p = 1'b0, dv_c_p = 1'b0;
    logic [6:0] last_c = '0, prev_c = '0;

    uart_rx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_a),
        .data_out(dout_a), .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a)
    );

    uart_rx_cfg #(.PARITY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_b),
        .data_out(dout_b), .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b)
    );

    uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_c),
        .data_out(dout_c), .data_valid(dv_c), .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c)
    );

    always #5 clk = ~clk;

    always @(negedge clk) sample_tick = ~sample_tick;

    always @(negedge clk) begin
        if (dv_a) cnt_a++;
        if (dv_b) cnt_b++;
        if (dv_c) begin
            cnt_c++;
            prev_c = last_c;
            last_c = dout_c;
        end
        if ((dv_a && dv_a_p) || (dv_b && dv_b_p) || (dv_c && dv_c_p)) wide++;
        dv_a_p = dv_a;
        dv_b_p = dv_b;
        dv_c_p = dv_c;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int sel, input logic val, input int n);
        case (sel)
            0: rx_a = val;
            1: rx_b = val;
            default: rx_c = val;
        endcase
        wait_ticks(n);
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) drive(sel, bits[i], 16);
    endtask

    task automatic test_reset;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_dout_a: got %h expected 00", dout_a); end
        n_checks++; if ({dv_a, pe_a, fe_a, bk_a} !== 4'b0) begin n_fail++; $display("FAIL reset_flags_a: got %b expected 0000", {dv_a, pe_a, fe_a, bk_a}); end
        n_checks++; if ({dout_b, dv_b, pe_b, fe_b, bk_b} !== 12'h000) begin n_fail++; $display("FAIL reset_outputs_b: got %h expected 000", {dout_b, dv_b, pe_b, fe_b, bk_b}); end
        n_checks++; if ({dout_c, dv_c, pe_c, fe_c, bk_c} !== 11'h000) begin n_fail++; $display("FAIL reset_outputs_c: got %h expected 000", {dout_c, dv_c, pe_c, fe_c, bk_c}); end
        rst_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic;
        int base;
        base = cnt_a;
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
        wait_ticks(4);
        n_checks++; if (cnt_a !== base + 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected %0d", cnt_a - base, 1); end
        n_checks++; if (dout_a !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", dout_a); end
        n_checks++; if ({pe_a, fe_a, bk_a} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b expected 000", {pe_a, fe_a, bk_a}); end
    endtask

    task automatic test_glitch;
        int base;
        base = cnt_a;
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 20);
        n_checks++; if (cnt_a !== base) begin n_fail++; $display("FAIL glitch_no_valid: got %0d pulses expected 0", cnt_a - base); end
        send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
        wait_ticks(4);
        n_checks++; if (cnt_a !== base + 1) begin n_fail++; $display("FAIL glitch_follow_count: got %0d expected 1", cnt_a - base); end
        n_checks++; if (dout_a !== 8'h3C) begin n_fail++; $display("FAIL glitch_follow_data: got %h expected 3c", dout_a); end
    endtask

    task automatic test_parity;
        int base;
        base = cnt_b;
        send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        wait_ticks(4);
        n_checks++; if (pe_b !== 1'b1) begin n_fail++; $display("FAIL parity_bad_flag: got %b expected 1", pe_b); end
        n_checks++; if (dout_b !== 8'h03) begin n_fail++; $display("FAIL parity_bad_data: got %h expected 03", dout_b); end
        n_checks++; if (fe_b !== 1'b0) begin n_fail++; $display("FAIL parity_bad_ferr: got %b expected 0", fe_b); end
        send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        wait_ticks(4);
        n_checks++; if (pe_b !== 1'b0) begin n_fail++; $display("FAIL parity_good_flag: got %b expected 0", pe_b); end
        n_checks++; if (cnt_b !== base + 2) begin n_fail++; $display("FAIL parity_valid_count: got %0d expected 2", cnt_b - base); end
    endtask

    task automatic test_frame_err;
        int base;
        base = cnt_a;
        send_bits(0, {1'b0, 8'h55, 1'b0}, 10);
        drive(0, 1'b1, 16);
        n_checks++; if ({fe_a, bk_a} !== 2'b10) begin n_fail++; $display("FAIL ferr_55_flags: got fe,bk=%b expected 10", {fe_a, bk_a}); end
        n_checks++; if (dout_a !== 8'h55) begin n_fail++; $display("FAIL ferr_55_data: got %h expected 55", dout_a); end
        send_bits(0, {1'b0, 8'h00, 1'b0}, 10);
        drive(0, 1'b0, 16);
        n_checks++; if ({fe_a, bk_a} !== 2'b11) begin n_fail++; $display("FAIL break_flags: got fe,bk=%b expected 11", {fe_a, bk_a}); end
        n_checks++; if (cnt_a !== base + 2) begin n_fail++; $display("FAIL break_valid_count: got %0d expected 2", cnt_a - base); end
        drive(0, 1'b1, 4);
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        wait_ticks(4);
        n_checks++; if (cnt_a !== base + 3) begin n_fail++; $display("FAIL unarmed_valid_count: got %0d expected 3", cnt_a - base); end
        n_checks++; if (dout_a !== 8'h5A) begin n_fail++; $display("FAIL unarmed_follow_data: got %h expected 5a", dout_a); end
        n_checks++; if ({fe_a, bk_a} !== 2'b00) begin n_fail++; $display("FAIL unarmed_follow_flags: got %b expected 00", {fe_a, bk_a}); end
    endtask

    task automatic test_back_to_back;
        int base;
        send_bits(2, {1'b0, 1'b1, 7'h41, 1'b0}, 10);
        drive(2, 1'b1, 16);
        n_checks++; if (fe_c !== 1'b1) begin n_fail++; $display("FAIL stop2_low_ferr: got %b expected 1", fe_c); end
        n_checks++; if (dout_c !== 7'h41) begin n_fail++; $display("FAIL stop2_low_data: got %h expected 41", dout_c); end
        base = cnt_c;
        send_bits(2, {1'b1, 1'b1, 7'h12, 1'b0}, 10);
        send_bits(2, {1'b1, 1'b1, 7'h34, 1'b0}, 10);
        wait_ticks(4);
        n_checks++; if (cnt_c !== base + 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", cnt_c - base); end
        n_checks++; if (prev_c !== 7'h12) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 12", prev_c); end
        n_checks++; if (last_c !== 7'h34) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 34", last_c); end
        n_checks++; if (fe_c !== 1'b0) begin n_fail++; $display("FAIL b2b_ferr: got %b expected 0", fe_c); end
    endtask

    task automatic test_reset_mid;
        int base;
        base = cnt_a;
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 64 + 6);
        rst_n = 1'b0;
        #2;
        n_checks++; if ({dout_a, dv_a, pe_a, fe_a, bk_a} !== 12'h000) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 000", {dout_a, dv_a, pe_a, fe_a, bk_a}); end
        repeat (4) @(posedge clk);
        #1;
        rx_a = 1'b1;
        rst_n = 1'b1;
        wait_ticks(20);
        n_checks++; if (cnt_a !== base) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", cnt_a - base); end
        send_bits(0, {1'b1, 8'h7E, 1'b0}, 10);
        wait_ticks(4);
        n_checks++; if (cnt_a !== base + 1) begin n_fail++; $display("FAIL midreset_follow_count: got %0d expected 1", cnt_a - base); end
        n_checks++; if (dout_a !== 8'h7E) begin n_fail++; $display("FAIL midreset_follow_data: got %h expected 7e", dout_a); end
    endtask

    task automatic test_valid_width;
        n_checks++; if (wide !== 0) begin n_fail++; $display("FAIL valid_single_clk: got %0d long pulses expected 0", wide); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_valid_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
